// File: rtl/multi_edge_detector.sv
// multi_edge_detector: N-channel resynchronise -> debounce -> edge detect.
// Each channel is an independent med_lane instance; the top only packs
// the lane outputs and registers the combined interrupt.

module med_lane #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 1,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic             eout,
   output logic             pending,
   output logic             pending_nxt,
   output logic [CNT_W-1:0] count,
   output logic             level
);
   localparam int HC_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [HC_W-1:0] HC_MAX = HC_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic            s;
   logic [HC_W-1:0] hc;
   logic            upd;
   logic            hit;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign s = din;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync;
         // Plain shift chain; s is the oldest stage.
         always_ff @(posedge clk) begin
            if (rst) begin
               sync <= '0;
            end else begin
               sync[0] <= din;
               for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            end
         end
         assign s = sync[SYNC_STAGES-1];
      end
   endgenerate

   // A new level is accepted on the cycle it has been seen DEBOUNCE times in a row.
   assign upd         = (s != level) && (hc == HC_MAX);
   assign hit         = upd & ((mode[0] & s) | (mode[1] & ~s));
   // A coincident clear never swallows a fresh edge.
   assign pending_nxt = hit | (pending & ~clr);

   // Debounce: any return of s to the filtered level restarts the hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= 1'b0;
         hc    <= '0;
      end else if (s == level) begin
         hc    <= '0;
      end else if (hc == HC_MAX) begin
         level <= s;
         hc    <= '0;
      end else begin
         hc    <= hc + HC_W'(1);
      end
   end

   // Edge pulse, sticky flag and saturating counter all move on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         eout    <= 1'b0;
         pending <= 1'b0;
         count   <= '0;
      end else begin
         eout    <= hit;
         pending <= pending_nxt;
         if (clr && hit)            count <= CNT_W'(1);
         else if (clr)              count <= '0;
         else if (hit && count != CNT_MAX) count <= count + CNT_W'(1);
      end
   end
endmodule

module multi_edge_detector #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 1,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       din,
   input  logic [2*N_CH-1:0]     mode,
   input  logic [N_CH-1:0]       clr,
   output logic [N_CH-1:0]       eout,
   output logic [N_CH-1:0]       pending,
   output logic [CNT_W*N_CH-1:0] count,
   output logic [N_CH-1:0]       level,
   output logic                  irq
);
   logic [N_CH-1:0][1:0]       mode_arr;
   logic [N_CH-1:0][CNT_W-1:0] cnt_arr;
   logic [N_CH-1:0]            pend_nxt;

   assign mode_arr = mode;
   assign count    = cnt_arr;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_lane
         med_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .CNT_W       (CNT_W)
         ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .din         (din[i]),
            .mode        (mode_arr[i]),
            .clr         (clr[i]),
            .eout        (eout[i]),
            .pending     (pending[i]),
            .pending_nxt (pend_nxt[i]),
            .count       (cnt_arr[i]),
            .level       (level[i])
         );
      end
   endgenerate

   // irq follows the pending flags on the same edge they change.
   always_ff @(posedge clk) begin
      if (rst) irq <= 1'b0;
      else     irq <= |pend_nxt;
   end
endmodule
